mem_port_arbiter: RTL and testbench



---
 rtl/rv_mem_pkg.sv | 18 +
 rtl/mem_port_arbiter_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared memory-port definitions: geometry, the word-address slice and the alignment check.
package rv_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 6;
  localparam logic [DATA_W-1:0] NOP_INSN = 32'h0000_0033;

  // Byte address to word index; upper bits fall away, so accesses wrap every 256 bytes.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr[MEM_AW+1:2];
  endfunction

  function automatic logic is_aligned(input logic [ADDR_W-1:0] byte_addr);
    return (byte_addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles an eligible fetch lost its slot to data.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports: same-cycle grant, registered
// response one cycle later; data wins unless fetch has been starved STARVE_LIMIT cycles.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic f_elig;
  logic d_elig;
  logic d_aligned;
  logic at_limit;

  assign f_elig    = i_req && !i_flush && !rst;
  assign d_elig    = d_req && !rst;
  assign d_aligned = is_aligned(d_addr);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (d_elig && (!f_elig || !at_limit)) begin
      d_gnt = 1'b1;
    end else if (f_elig) begin
      i_gnt = 1'b1;
    end
  end

  // A misaligned data access still takes the slot but never reaches the memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = word_addr(i_addr);
    end else if (d_gnt) begin
      mem_addr  = word_addr(d_addr);
      mem_wdata = d_wdata;
      if (d_aligned) begin
        mem_en = 1'b1;
        mem_we = d_we;
      end
    end
  end

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (f_elig && d_gnt),
    .clr      (i_gnt || !i_req || i_flush),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt && !d_aligned;
      if (i_gnt) begin
        i_rdata <= mem_rdata;
      end
      if (d_gnt) begin
        d_rdata <= (d_aligned && !d_we) ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64-word memory behind the port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic test_reset;
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h4; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h55;
    #1;
    n_cmp++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_i_gnt got %b want 0", i_gnt); end
    n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL rst_mem_en_we got %b want 00", {mem_en, mem_we}); end
    n_cmp++; if ({i_rvalid, d_rvalid, d_err} !== 3'b000) begin n_fail++; $display("FAIL rst_valids got %b want 000", {i_rvalid, d_rvalid, d_err}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", {i_rdata, d_rdata}); end
    @(negedge clk);
    n_cmp++; if (mem[0] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rst_no_write got %h want a5a50001", mem[0]); end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_fetch;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4;
    #1;
    n_cmp++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt got %b want 10", {i_gnt, d_gnt}); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL fetch_mem_en_we got %b want 10", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 6'd1) begin n_fail++; $display("FAIL fetch_mem_addr got %0d want 1", mem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (i_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid got %b want 1", i_rvalid); end
    n_cmp++; if (i_rdata !== 32'h0000_2083) begin n_fail++; $display("FAIL fetch_rdata got %h want 00002083", i_rdata); end
    @(negedge clk);
    i_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_single_rvalid got %b want 0", i_rvalid); end
    n_cmp++; if (i_rdata !== 32'h0000_2083) begin n_fail++; $display("FAIL fetch_rdata_hold got %h want 00002083", i_rdata); end
  endtask

  task automatic test_store_load;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0C; d_wdata = 32'h22;
    #1;
    n_cmp++; if ({d_gnt, mem_en, mem_we} !== 3'b111) begin n_fail++; $display("FAIL st_gnt_en_we got %b want 111", {d_gnt, mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 6'd3) begin n_fail++; $display("FAIL st_mem_addr got %0d want 3", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h22) begin n_fail++; $display("FAIL st_mem_wdata got %h want 22", mem_wdata); end
    @(posedge clk); #1;
    n_cmp++; if ({d_rvalid, d_err} !== 2'b10) begin n_fail++; $display("FAIL st_ack got %b want 10", {d_rvalid, d_err}); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL st_ack_rdata got %h want 0", d_rdata); end
    @(negedge clk);
    d_we = 1'b0;
    #1;
    n_cmp++; if ({d_gnt, mem_en, mem_we} !== 3'b110) begin n_fail++; $display("FAIL ld_gnt_en_we got %b want 110", {d_gnt, mem_en, mem_we}); end
    @(posedge clk); #1;
    n_cmp++; if ({d_rvalid, d_err} !== 2'b10) begin n_fail++; $display("FAIL ld_rvalid got %b want 10", {d_rvalid, d_err}); end
    n_cmp++; if (d_rdata !== 32'h22) begin n_fail++; $display("FAIL ld_rdata got %h want 22", d_rdata); end
    // 0x10C aliases 0x0C once the address wraps at 256 bytes.
    @(negedge clk);
    d_addr = 32'h10C;
    #1;
    n_cmp++; if (mem_addr !== 6'd3) begin n_fail++; $display("FAIL wrap_mem_addr got %0d want 3", mem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (d_rdata !== 32'h22) begin n_fail++; $display("FAIL wrap_rdata got %h want 22", d_rdata); end
    @(negedge clk);
    d_req = 1'b0;
  endtask

  // Both ports held: data wins while the counter climbs to 4, then fetch takes one slot.
  task automatic run_contention(input int cycles, input int i_slot_mod, input string tag);
    logic exp_i;
    for (int c = 0; c < cycles; c++) begin
      exp_i = ((c % 5) == i_slot_mod);
      #1;
      n_cmp++;
      if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        n_fail++; $display("FAIL %s_cyc%0d got i/d=%b want %b", tag, c, {i_gnt, d_gnt}, {exp_i, ~exp_i});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    run_contention(10, 4, "contend");
    run_contention(3, 4, "contend_pre");
  endtask

  task automatic test_flush;
    i_flush = 1'b1; d_req = 1'b0;
    #1;
    n_cmp++; if ({i_gnt, d_gnt, mem_en} !== 3'b000) begin n_fail++; $display("FAIL flush_block got %b want 000", {i_gnt, d_gnt, mem_en}); end
    @(negedge clk);
    i_flush = 1'b0; d_req = 1'b1;
    // Counter was at 3 before the flush; a cleared counter gives data four full slots again.
    run_contention(5, 4, "post_flush");
    d_req = 1'b0;
    #1;
    n_cmp++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL flush_release got %b want 1", i_gnt); end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0E; i_req = 1'b1;
    #1;
    n_cmp++; if ({d_gnt, i_gnt, mem_en} !== 3'b100) begin n_fail++; $display("FAIL mis_gnt got d/i/en=%b want 100", {d_gnt, i_gnt, mem_en}); end
    @(posedge clk); #1;
    n_cmp++; if ({d_rvalid, d_err} !== 2'b11) begin n_fail++; $display("FAIL mis_resp got %b want 11", {d_rvalid, d_err}); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", d_rdata); end
    @(negedge clk);
    d_req = 1'b0; i_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({d_rvalid, d_err} !== 2'b00) begin n_fail++; $display("FAIL mis_clear got %b want 00", {d_rvalid, d_err}); end
  endtask

  task automatic test_reset_midop;
    int spurious;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; i_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if ({d_rvalid, i_rvalid, d_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_valids got %b want 000", {d_rvalid, i_rvalid, d_err}); end
    n_cmp++; if ({d_rdata, i_rdata} !== 64'h0) begin n_fail++; $display("FAIL midrst_rdata got %h want 0", {d_rdata, i_rdata}); end
    n_cmp++; if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt got %b want 0000", {i_gnt, d_gnt, mem_en, mem_we}); end
    @(negedge clk);
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (i_rvalid || d_rvalid) spurious++;
    end
    n_cmp++; if (spurious !== 0) begin n_fail++; $display("FAIL midrst_spurious got %0d want 0", spurious); end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h0000_0033;
    mem[0] = 32'hA5A5_0001;
    mem[1] = 32'h0000_2083;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_flush();
    test_misaligned();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1);
  end

endmodule
